// File: rtl/counter_seq_checker.sv
// Receive-side checker for a wrapping LO..HI sequence counter: hunts, acquires lock
// after LOCK_LEN correct steps, then flags, counts and reports sequence errors and wraps.
module counter_seq_checker #(
    parameter int WIDTH     = 3,
    parameter int LO        = 2,
    parameter int HI        = 4,
    parameter int LOCK_LEN  = 3,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_val,
    output logic                 locked,
    output logic [WIDTH-1:0]     expected,
    output logic                 seq_err,
    output logic                 out_of_range,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     last, last_n;
    logic [RUN_W-1:0]     run, run_n;
    logic [ERR_CNT_W-1:0] cnt_n;
    logic                 seq_n, oor_n, wrap_n;
    logic                 in_range, step_ok;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
        return (v == HI_V) ? LO_V : WIDTH'(v + 1'b1);
    endfunction

    assign in_range = (in_val >= LO_V) && (in_val <= HI_V);
    assign step_ok  = (in_val == nxt(last));

    always_comb begin
        state_n = state;
        last_n  = last;
        run_n   = run;
        cnt_n   = err_count;
        seq_n   = 1'b0;
        oor_n   = 1'b0;
        wrap_n  = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_range) begin
                        last_n  = in_val;
                        run_n   = '0;
                        state_n = ACQUIRE;
                    end else begin
                        oor_n = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!in_range) begin
                        oor_n   = 1'b1;
                        state_n = HUNT;
                    end else if (step_ok) begin
                        last_n = in_val;
                        run_n  = run + 1'b1;
                        if (run_n == RUN_W'(LOCK_LEN))
                            state_n = LOCKED;
                    end else begin
                        last_n = in_val;
                        run_n  = '0;
                    end
                end
                LOCKED: begin
                    if (in_range && step_ok) begin
                        last_n = in_val;
                        wrap_n = (in_val == LO_V);
                    end else begin
                        // any break in sequence while locked is an error, counted once
                        seq_n = 1'b1;
                        if (err_count != '1)
                            cnt_n = err_count + 1'b1;
                        if (in_range) begin
                            last_n  = in_val;
                            run_n   = '0;
                            state_n = ACQUIRE;
                        end else begin
                            oor_n   = 1'b1;
                            state_n = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            last         <= '0;
            run          <= '0;
            err_count    <= '0;
            locked       <= 1'b0;
            expected     <= '0;
            seq_err      <= 1'b0;
            out_of_range <= 1'b0;
            wrap_pulse   <= 1'b0;
        end else begin
            state        <= state_n;
            last         <= last_n;
            run          <= run_n;
            err_count    <= cnt_n;
            locked       <= (state_n == LOCKED);
            expected     <= (state_n == HUNT) ? '0 : nxt(last_n);
            seq_err      <= seq_n;
            out_of_range <= oor_n;
            wrap_pulse   <= wrap_n;
        end
    end
endmodule

// File: tb/tb_counter_seq_checker.sv
// Randomized + directed bench for counter_seq_checker against a sample-level reference model;
// a second instance with a 2-bit error counter exercises saturation.
module tb_counter_seq_checker;
    localparam int W = 3, LO = 2, HI = 4, LL = 3;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [W-1:0] in_val = '0;
    logic locked, seq_err, oor, wrap;
    logic [W-1:0] expected;
    logic [7:0] err_count;
    logic s_locked, s_seq, s_oor, s_wrap;
    logic [W-1:0] s_expected;
    logic [1:0] s_err;

    counter_seq_checker #(.WIDTH(W), .LO(LO), .HI(HI), .LOCK_LEN(LL), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val),
        .locked(locked), .expected(expected), .seq_err(seq_err),
        .out_of_range(oor), .wrap_pulse(wrap), .err_count(err_count));

    counter_seq_checker #(.WIDTH(W), .LO(LO), .HI(HI), .LOCK_LEN(LL), .ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val),
        .locked(s_locked), .expected(s_expected), .seq_err(s_seq),
        .out_of_range(s_oor), .wrap_pulse(s_wrap), .err_count(s_err));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0=hunt 1=acquire 2=locked, one step per valid sample.
    int m_mode, m_last, m_run, m_errs;
    bit m_seq, m_oor, m_wrap;

    function automatic int succ(input int v);
        return ((v - LO + 1) % (HI - LO + 1)) + LO;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_last = 0; m_run = 0; m_errs = 0;
        m_seq = 0; m_oor = 0; m_wrap = 0;
    endtask

    task automatic m_step(input bit v, input int x);
        bit inr;
        m_seq = 0; m_oor = 0; m_wrap = 0;
        if (!v) return;
        inr = (x >= LO) && (x <= HI);
        if (m_mode == 0) begin
            if (inr) begin m_last = x; m_run = 0; m_mode = 1; end
            else m_oor = 1;
        end else if (m_mode == 1) begin
            if (!inr) begin m_oor = 1; m_mode = 0; end
            else if (x == succ(m_last)) begin
                m_run++; m_last = x;
                if (m_run == LL) m_mode = 2;
            end else begin m_last = x; m_run = 0; end
        end else begin
            if (inr && x == succ(m_last)) begin
                m_last = x; m_wrap = (x == LO);
            end else begin
                m_seq = 1; m_errs++;
                if (inr) begin m_last = x; m_run = 0; m_mode = 1; end
                else begin m_oor = 1; m_mode = 0; end
            end
        end
    endtask

    task automatic check_all();
        int e;
        e = (m_mode == 0) ? 0 : succ(m_last);
        chk("locked", locked, m_mode == 2);
        chk("expected", expected, e);
        chk("seq_err", seq_err, m_seq);
        chk("out_of_range", oor, m_oor);
        chk("wrap_pulse", wrap, m_wrap);
        chk("err_count", err_count, min_i(m_errs, 255));
        chk("s_locked", s_locked, m_mode == 2);
        chk("s_expected", s_expected, e);
        chk("s_seq_err", s_seq, m_seq);
        chk("s_err_count", s_err, min_i(m_errs, 3));
    endtask

    task automatic cyc(input bit v, input int x);
        @(negedge clk);
        in_valid = v;
        in_val   = W'(x);
        @(posedge clk);
        m_step(v, x);
        #1;
        check_all();
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_expected"}, expected, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_s_err_count"}, s_err, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r, x, nv;
        m_reset();
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_expected", expected, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Lock on 2,3,4,2 then follow through a wrap.
        cyc(1, 2); cyc(1, 3); cyc(1, 4);
        chk("t1_not_yet", locked, 0);
        cyc(1, 2);
        chk("t1_locked", locked, 1);
        cyc(1, 3); chk("t1_exp4", expected, 4);
        cyc(1, 4); chk("t1_exp2", expected, 2);
        cyc(1, 2); chk("t1_wrap", wrap, 1); chk("t1_exp3", expected, 3);
        cyc(1, 3); chk("t1_wrap_once", wrap, 0);

        // Mismatch while locked (expected 2, drive 3), then relock.
        cyc(1, 4); cyc(1, 3);
        chk("t2_seq", seq_err, 1); chk("t2_cnt", err_count, 1);
        chk("t2_unlock", locked, 0); chk("t2_exp", expected, 4);
        cyc(1, 4); cyc(1, 2); cyc(1, 3);
        chk("t2_relock", locked, 1);

        // Out-of-range while locked, then out-of-range in hunt.
        cyc(1, 7);
        chk("t3_seq", seq_err, 1); chk("t3_oor", oor, 1);
        chk("t3_cnt", err_count, 2); chk("t3_exp", expected, 0);
        cyc(1, 0);
        chk("t3_hunt_oor", oor, 1); chk("t3_hunt", locked, 0);

        // Idle gaps with garbage on the bus.
        cyc(1, 2); cyc(1, 3); cyc(1, 4); cyc(1, 2); cyc(1, 3);
        for (int i = 0; i < 5; i++) cyc(0, $urandom_range(0, 7));
        chk("t4_exp", expected, 4); chk("t4_locked", locked, 1);
        cyc(1, 4);
        chk("t4_no_err", seq_err, 0);

        // Async reset mid-operation, then relock from 4.
        async_reset("t6");
        cyc(1, 4); cyc(1, 2); cyc(1, 3);
        chk("t6_not_yet", locked, 0);
        cyc(1, 4);
        chk("t6_locked", locked, 1);

        // Randomized traffic with occasional async resets.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            nv = (m_mode == 0) ? $urandom_range(LO, HI) : succ(m_last);
            if (r < 12)      cyc(0, $urandom_range(0, 7));
            else if (r < 75) cyc(1, nv);
            else if (r < 90) cyc(1, $urandom_range(LO, HI));
            else begin
                x = $urandom_range(0, 7);
                cyc(1, x);
            end
            if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_seq_checker.md
Name: counter_seq_checker

Overview:
- Receive-side checker for the free-running sequence counter that cycles 2 -> 3 -> 4 -> 2 on a 3-bit bus.
- Samples the counter value when `in_valid` is high and acquires lock after a run of correct steps.
- Once locked, it flags sequence errors, counts them, and pulses once per completed wrap.
- Sits on the consumer side of the counter bus; used for self-check in system builds and for bring-up.

Parameters:
- WIDTH, 3: width of the sampled counter bus.
- LO, 2: first (wrap-target) value of the sequence.
- HI, 4: last value before wrap. Requires LO < HI <= 2^WIDTH-1.
- LOCK_LEN, 3: consecutive correct steps needed to enter LOCKED. Must be >= 1.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  sample strobe; in_val is sampled only when high
- in_val  input  WIDTH  counter value under check
- locked  output  1  high while the state is LOCKED
- expected  output  WIDTH  next value expected; 0 in HUNT
- seq_err  output  1  one-cycle pulse on a mismatch while LOCKED
- out_of_range  output  1  one-cycle pulse when a sampled value is outside [LO,HI]
- wrap_pulse  output  1  one-cycle pulse when LOCKED and a correct LO sample arrives (HI -> LO step)
- err_count  output  ERR_CNT_W  saturating count of seq_err events

Behaviour:
- Reset is decided: one clock, `clk`; asynchronous active-high reset `rst`.
- While `rst` is high, immediately:
  - state = HUNT, last = 0, run = 0
  - all outputs = 0, err_count = 0
- All outputs are registered. Response appears one cycle after the sampling edge.
- Pulse outputs are low in any cycle with no qualifying sample.
- `in_valid` = 0: state, last, run and err_count hold; all pulses are 0.
- Define next(v) = LO if v == HI, else v + 1, computed in WIDTH bits.
- Define in_range = (LO <= in_val <= HI).
- HUNT (on a valid sample):
  - in_range: last = in_val, run = 0, go to ACQUIRE.
  - otherwise: pulse out_of_range, stay in HUNT.
- ACQUIRE (on a valid sample):
  - in_val == next(last): run = run + 1, last = in_val. If the new run == LOCK_LEN, go to LOCKED.
  - in_range but wrong: last = in_val, run = 0, stay in ACQUIRE. No seq_err.
  - not in_range: pulse out_of_range, go to HUNT.
- LOCKED (on a valid sample):
  - in_val == next(last): last = in_val. If in_val == LO, pulse wrap_pulse.
  - in_range mismatch: pulse seq_err, increment err_count, last = in_val, run = 0, go to ACQUIRE.
  - not in_range: pulse seq_err and out_of_range in the same cycle, increment err_count, go to HUNT.
- Register and output rules:
  - run is wide enough to hold LOCK_LEN.
  - expected = next(last) in ACQUIRE and LOCKED; 0 in HUNT.
  - locked tracks the state register, so it drops in the cycle after a mismatch.
  - err_count saturates at 2^ERR_CNT_W - 1 and is cleared only by `rst`.
- Minimum lock time: 1 + LOCK_LEN valid samples from HUNT.
- Reset asserted mid-operation aborts everything immediately. There is no partial-lock retention.

Test Plan:
1. Reset, then in_valid = 1 with in_val = 2,3,4,2 (LOCK_LEN = 3) -> locked = 0 through the third response, locked = 1 the cycle after sample 2. Continue with 3,4,2 -> expected shows 4,2,3; wrap_pulse is high for exactly one cycle after the second 2.
2. Locked with expected = 2, drive in_val = 3 -> next cycle: seq_err = 1 for one cycle, err_count = 1, locked = 0, expected = 4. Then drive 4,2,3 -> locked = 1 again after the third correct step.
3. Locked, drive in_val = 7 -> seq_err = 1 and out_of_range = 1 in the same cycle, err_count + 1, locked = 0, expected = 0. Then drive 0 -> out_of_range pulses, state stays HUNT.
4. Locked at last = 3, in_valid = 0 for 5 cycles with garbage on in_val -> no pulses, expected stays 4, locked stays 1. Then valid 4 -> no error.
5. ERR_CNT_W = 2: lock, then force 5 mismatches, relocking between them -> err_count reads 1,2,3,3,3; seq_err pulses 5 times.
6. Locked with err_count = 2, assert rst asynchronously between clock edges -> locked, err_count and expected go to 0 before the next edge. Release rst, drive 4,2,3,4 -> locked = 1 after the fourth sample.
